// File: rtl/accel_bcd_conv.sv
// accel_bcd_conv: sequential signed-binary to BCD converter (double-dabble,
// one bit per clock) feeding per-digit 7-segment decoders. Produces a sign
// flag, an overflow flag with saturated digits, and optional leading-zero
// blanking using code 4'hF.
module accel_bcd_conv #(
   parameter int WIDTH    = 10,
   parameter int DIGITS   = 4,
   parameter int BLANK_LZ = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [WIDTH-1:0]      value,
   output logic                  busy,
   output logic                  done,
   output logic                  neg,
   output logic                  ovf,
   output logic [4*DIGITS-1:0]   bcd
);

   localparam int BW = 4 * DIGITS;

   // 10^n as a 32-bit constant; DIGITS <= 5 keeps this far from overflow
   function automatic logic [31:0] pow10(input int n);
      logic [31:0] r;
      r = 32'd1;
      for (int i = 0; i < n; i++) begin
         r = r * 32'd10;
      end
      return r;
   endfunction

   localparam logic [31:0] MAX_VAL  = pow10(DIGITS) - 32'd1;
   localparam logic [4:0]  CNT_LAST = 5'(WIDTH - 1);

   // Double-dabble correction: every digit of 5 or more gets +3 before the shift
   function automatic logic [BW-1:0] add3_digits(input logic [BW-1:0] d);
      logic [BW-1:0] r;
      r = d;
      for (int k = 0; k < DIGITS; k++) begin
         if (d[4*k +: 4] >= 4'd5) begin
            r[4*k +: 4] = d[4*k +: 4] + 4'd3;
         end else begin
            r[4*k +: 4] = d[4*k +: 4];
         end
      end
      return r;
   endfunction

   // Replace zero digits above the most significant nonzero digit with 4'hF;
   // the ones digit is always shown
   function automatic logic [BW-1:0] blank_lz(input logic [BW-1:0] d);
      logic [BW-1:0] r;
      logic          lead;
      r    = d;
      lead = 1'b1;
      for (int k = DIGITS - 1; k >= 1; k--) begin
         if (lead && (d[4*k +: 4] == 4'h0)) begin
            r[4*k +: 4] = 4'hF;
         end else begin
            lead = 1'b0;
         end
      end
      return r;
   endfunction

   // Digit pattern shown after reset: a lone zero, blanked above if enabled
   function automatic logic [BW-1:0] reset_bcd();
      if (BLANK_LZ != 0) begin
         return blank_lz({BW{1'b0}});
      end else begin
         return {BW{1'b0}};
      end
   endfunction

   // Final digit formatting applied on the FINISH edge
   function automatic logic [BW-1:0] format_bcd(input logic [BW-1:0] d,
                                                input logic         sat);
      logic [BW-1:0] r;
      if (sat) begin
         r = {DIGITS{4'h9}};
      end else begin
         r = d;
      end
      if (BLANK_LZ != 0) begin
         return blank_lz(r);
      end else begin
         return r;
      end
   endfunction

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      FINISH = 2'd2
   } state_t;

   state_t              state_r;
   logic [4:0]          cnt_r;
   logic [WIDTH-1:0]    mag_r;
   logic [BW-1:0]       scratch_r;
   logic                neg_r;
   logic                ovf_r;

   logic [WIDTH-1:0]    abs_s;
   logic                ovf_s;
   logic [BW-1:0]       adj_s;

   // Magnitude of the incoming sample (the most negative value maps to
   // 2^(WIDTH-1) without wrap because the result is read as unsigned),
   // its range check, and the add-3 corrected scratch for this iteration
   always_comb begin
      abs_s = value;
      if (value[WIDTH-1]) begin
         abs_s = ~value + WIDTH'(1);
      end else begin
         abs_s = value;
      end
      ovf_s = (32'(abs_s) > MAX_VAL);
      adj_s = add3_digits(scratch_r);
   end

   // Conversion FSM; all outputs are registered and only change on FINISH
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= IDLE;
         cnt_r     <= 5'd0;
         mag_r     <= {WIDTH{1'b0}};
         scratch_r <= {BW{1'b0}};
         neg_r     <= 1'b0;
         ovf_r     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         neg       <= 1'b0;
         ovf       <= 1'b0;
         bcd       <= reset_bcd();
      end else begin
         done <= 1'b0;
         case (state_r)
            IDLE: begin
               if (start) begin
                  mag_r     <= abs_s;
                  neg_r     <= value[WIDTH-1] && (abs_s != {WIDTH{1'b0}});
                  ovf_r     <= ovf_s;
                  cnt_r     <= 5'd0;
                  scratch_r <= {BW{1'b0}};
                  busy      <= 1'b1;
                  state_r   <= SHIFT;
               end else begin
                  busy      <= 1'b0;
               end
            end
            SHIFT: begin
               // {scratch, mag} shifts left by one after the +3 correction
               scratch_r <= {adj_s[BW-2:0], mag_r[WIDTH-1]};
               mag_r     <= {mag_r[WIDTH-2:0], 1'b0};
               cnt_r     <= cnt_r + 5'd1;
               if (cnt_r == CNT_LAST) begin
                  state_r <= FINISH;
               end else begin
                  state_r <= SHIFT;
               end
            end
            FINISH: begin
               bcd     <= format_bcd(scratch_r, ovf_r);
               neg     <= neg_r;
               ovf     <= ovf_r;
               done    <= 1'b1;
               busy    <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               busy    <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_accel_bcd_conv.sv
// Testbench for accel_bcd_conv: three instances (default, BLANK_LZ=0,
// DIGITS=2) share stimulus and are compared against a decimal reference model.
module tb_accel_bcd_conv;

   localparam int W = 10;

   logic          clk;
   logic          rst;
   logic          start;
   logic [W-1:0]  value;

   logic          busy_a, done_a, neg_a, ovf_a;
   logic [15:0]   bcd_a;
   logic          busy_b, done_b, neg_b, ovf_b;
   logic [15:0]   bcd_b;
   logic          busy_c, done_c, neg_c, ovf_c;
   logic [7:0]    bcd_c;

   int checks;
   int errors;

   // expected values currently displayed and those due at the next done
   logic [31:0] cur_a, cur_b, cur_c, nxt_a, nxt_b, nxt_c;
   logic        cur_neg, nxt_neg;
   logic        cur_ovf_a, cur_ovf_c, nxt_ovf_a, nxt_ovf_c;

   accel_bcd_conv #(.WIDTH(W), .DIGITS(4), .BLANK_LZ(1)) dut_a (
      .clk(clk), .rst(rst), .start(start), .value(value),
      .busy(busy_a), .done(done_a), .neg(neg_a), .ovf(ovf_a), .bcd(bcd_a));

   accel_bcd_conv #(.WIDTH(W), .DIGITS(4), .BLANK_LZ(0)) dut_b (
      .clk(clk), .rst(rst), .start(start), .value(value),
      .busy(busy_b), .done(done_b), .neg(neg_b), .ovf(ovf_b), .bcd(bcd_b));

   accel_bcd_conv #(.WIDTH(W), .DIGITS(2), .BLANK_LZ(1)) dut_c (
      .clk(clk), .rst(rst), .start(start), .value(value),
      .busy(busy_c), .done(done_c), .neg(neg_c), .ovf(ovf_c), .bcd(bcd_c));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: plain decimal arithmetic on the signed sample
   function automatic logic [31:0] model_bcd(input logic [W-1:0] v, input int nd,
                                             input bit blank, output bit n, output bit o);
      int sv, mag, lim, hi;
      int dg[5];
      logic [31:0] r;
      sv  = v[W-1] ? (int'(v) - 1024) : int'(v);
      mag = (sv < 0) ? -sv : sv;
      n   = (sv < 0);
      lim = 1;
      for (int k = 0; k < nd; k++) lim = lim * 10;
      o   = (mag > lim - 1);
      for (int k = 0; k < nd; k++) begin
         dg[k] = o ? 9 : mag % 10;
         mag   = mag / 10;
      end
      hi = 0;
      for (int k = 0; k < nd; k++) if (dg[k] != 0) hi = k;
      r = 32'd0;
      for (int k = 0; k < nd; k++) begin
         r[4*k +: 4] = (blank && k > hi) ? 4'hF : 4'(dg[k]);
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_reset_expect();
      cur_a = 32'h0000_FFF0; cur_b = 32'h0000_0000; cur_c = 32'h0000_00F0;
      cur_neg = 1'b0; cur_ovf_a = 1'b0; cur_ovf_c = 1'b0;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_busy"}, 32'(busy_a | busy_b | busy_c), 32'd0);
      chk({tag, "_done"}, 32'(done_a | done_b | done_c), 32'd0);
      chk({tag, "_negovf"}, 32'({neg_a, ovf_a, neg_c, ovf_c}), 32'd0);
      chk({tag, "_bcd_a"}, 32'(bcd_a), 32'h0000_FFF0);
      chk({tag, "_bcd_b"}, 32'(bcd_b), 32'h0000_0000);
      chk({tag, "_bcd_c"}, 32'(bcd_c), 32'h0000_00F0);
   endtask

   // Present a sample on the next edge and compute the result it should give
   task automatic launch(input logic [W-1:0] v);
      bit n, o;
      start = 1'b1;
      value = v;
      nxt_a = model_bcd(v, 4, 1'b1, n, o); nxt_neg = n; nxt_ovf_a = o;
      nxt_b = model_bcd(v, 4, 1'b0, n, o);
      nxt_c = model_bcd(v, 2, 1'b1, n, o); nxt_ovf_c = o;
      tick();
      start = 1'b0;
      value = W'($urandom_range(0, 1023));
   endtask

   // Follow one conversion cycle by cycle; optionally pulse start mid-way
   task automatic track(input bit pulses);
      for (int i = 0; i <= W; i++) begin
         chk("busy_during", 32'({busy_a, busy_b, busy_c}), 32'h7);
         chk("done_during", 32'({done_a, done_b, done_c}), 32'h0);
         chk("bcd_hold", 32'({neg_a, bcd_a}), {15'd0, cur_neg, cur_a[15:0]});
         start = pulses && (i == 2 || i == 6);
         value = 10'd123;
         tick();
      end
      start = 1'b0;
      chk("done_pulse", 32'({done_a, done_b, done_c}), 32'h7);
      chk("busy_end", 32'({busy_a, busy_b, busy_c}), 32'h0);
      chk("bcd_a", 32'(bcd_a), nxt_a);
      chk("bcd_b", 32'(bcd_b), nxt_b);
      chk("bcd_c", 32'(bcd_c), nxt_c);
      chk("neg", 32'({neg_a, neg_b, neg_c}), {29'd0, {3{nxt_neg}}});
      chk("ovf", 32'({ovf_a, ovf_b, ovf_c}), {29'd0, nxt_ovf_a, nxt_ovf_a, nxt_ovf_c});
      cur_a = nxt_a; cur_b = nxt_b; cur_c = nxt_c;
      cur_neg = nxt_neg; cur_ovf_a = nxt_ovf_a; cur_ovf_c = nxt_ovf_c;
   endtask

   task automatic run_conv(input logic [W-1:0] v);
      launch(v);
      track(1'b0);
   endtask

   initial begin
      logic [W-1:0] dir_vals[10];
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      start  = 1'b0;
      value  = 10'd0;
      set_reset_expect();
      tick(); tick();
      chk_reset("reset");
      rst = 1'b0;
      tick();
      chk_reset("post_reset");

      // zero, then an idle cycle to see done fall
      run_conv(10'd0);
      tick();
      chk("done_one_cycle", 32'({done_a, busy_a}), 32'd0);

      dir_vals = '{10'h200, 10'd511, 10'h3FF, 10'd7, 10'd105,
                   10'd100, 10'd99, 10'd10, 10'h39C, 10'h201};
      foreach (dir_vals[i]) run_conv(dir_vals[i]);

      for (int r = 0; r < 20; r++) run_conv(W'($urandom_range(0, 1023)));

      // ignored mid-conversion starts, then back-to-back start on done cycle
      launch(10'd300);
      track(1'b1);
      chk("ignored_start_a", cur_a, 32'h0000_F300);
      launch(10'd42);
      track(1'b0);
      chk("b2b_a", cur_a, 32'h0000_FF42);

      // reset in the middle of a conversion
      launch(10'd250);
      tick(); tick(); tick(); tick();
      #3;
      rst = 1'b1;
      #1;
      set_reset_expect();
      chk_reset("abort");
      tick(); tick();
      rst = 1'b0;
      for (int i = 0; i < 15; i++) begin
         chk("no_done_after_abort", 32'({done_a, busy_a}), 32'd0);
         tick();
      end
      run_conv(10'd9);
      chk("after_abort_a", cur_a, 32'h0000_FFF9);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/accel_bcd_conv.md
Name: accel_bcd_conv

Overview:
- Sequential signed-binary to BCD converter for accelerometer axis readings, using shift-add-3 (double-dabble) with one bit per clock.
- Sits directly upstream of the per-digit 7-segment decoders.
- Each 4-bit digit of its output drives one decoder input.
- Supplies a separate sign flag for the minus-sign segment and blank codes for leading-zero suppression.

Parameters:
- WIDTH, 10, bit width of the two's-complement input sample. Must be 2..16.
- DIGITS, 4, number of BCD digits produced. Must be 1..5.
- BLANK_LZ, 1, 1 = leading zeros replaced by blank code 4'hF; 0 = leading zeros output as 4'h0.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  conversion request; sampled only in IDLE
- value  in  WIDTH  signed two's-complement sample; captured on the accepted start edge
- busy  out  1  high from accepted start until conversion completes
- done  out  1  one-cycle pulse; result outputs valid and updated
- neg  out  1  captured sample was negative
- ovf  out  1  magnitude exceeded 10^DIGITS-1; digits saturated
- bcd  out  4*DIGITS  digit k in bits [4k+3:4k], k=0 is ones; each digit 0..9 or 4'hF blank

Behaviour:
- Interface: one clock; reset is asynchronous and active-high. Clock port is clk, reset port is rst.
- Reset values: busy=0, done=0, neg=0, ovf=0.
- Reset value of bcd: ones digit 4'h0; higher digits 4'hF if BLANK_LZ=1, else 4'h0. State goes to IDLE.
- Reset mid-conversion aborts the conversion and discards partial results.
- FSM states: IDLE, SHIFT, FINISH.
- IDLE: start=1 at edge N captures the sample.
  - mag = |value|, computed WIDTH bits unsigned; -2^(WIDTH-1) maps to 2^(WIDTH-1) with no wrap.
  - neg_r = value[WIDTH-1] and mag!=0.
  - ovf_r = (mag > 10^DIGITS-1).
  - Shift counter cleared, BCD scratch cleared, busy=1, go to SHIFT.
- SHIFT: edges N+1..N+WIDTH each perform one iteration.
  - Every scratch digit >=5 gets +3.
  - Then {scratch,mag} shifts left by 1.
  - After iteration WIDTH, go to FINISH.
- FINISH: edge N+WIDTH+1 updates the outputs.
  - bcd = scratch, or all 4'h9 if ovf_r.
  - Leading-zero blanking applies when BLANK_LZ=1: scan from the most significant digit, and every zero digit above the first nonzero digit becomes 4'hF.
  - The ones digit is never blanked.
  - neg and ovf update; done=1, busy=0; go to IDLE.
- done is high for exactly one cycle, after edge N+WIDTH+1. Latency from start edge to done is WIDTH+1 cycles.
- start while busy (SHIFT or FINISH) is ignored, not queued.
- start during the done cycle (state IDLE) is accepted, giving back-to-back conversions every WIDTH+2 cycles.
- bcd, neg and ovf hold their previous values for the whole conversion. They change only on the FINISH edge, so the display never shows partial digits.
- The scratch register is 4*DIGITS bits wide. The ovf path bypasses it, so truncated shifts never reach the outputs.

Test Plan (WIDTH=10, DIGITS=4, BLANK_LZ=1 unless stated):
- Reset release, then start with value=10'd0 at edge 0 -> busy high edges 0..10; done pulse after edge 11; bcd=16'hFFF0, neg=0, ovf=0.
- value=10'h200 (-512) -> bcd=16'hF512, neg=1. value=10'd511 -> bcd=16'hF511, neg=0. value=10'h3FF (-1) -> bcd=16'hFFF1, neg=1.
- value=10'd7 with BLANK_LZ=0 -> bcd=16'h0007. Same value with BLANK_LZ=1 -> 16'hFFF7. value=10'd105 -> 16'hF105, internal zero kept.
- Pulse start again at edges 3 and 7 of a conversion of 10'd300, then start with 10'd42 on the done cycle -> the mid-conversion starts are ignored; result 16'hF300; second done exactly 12 cycles later with 16'hFF42.
- Assert rst at edge 5 of a conversion of 10'd250 -> outputs return to reset values immediately; no done pulse; next conversion of 10'd9 yields 16'hFFF9.
- DIGITS=2: value=10'd100 -> bcd=8'h99, ovf=1. value=10'd99 -> bcd=8'h99, ovf=0.
